// File: rtl/aes_inv_mix_columns_iter.sv
// aes_inv_mix_columns_iter: column-serial AES InvMixColumns with valid/ready handshakes
module aes_inv_mix_columns_iter (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;
  fsm_t fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [3:0][7:0] a, b;
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] v, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(v);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? v : 8'h00);
  endfunction
  function automatic logic [3:0] coef(input logic [1:0] i);
    return i == 2'd0 ? 4'he : i == 2'd1 ? 4'hb : i == 2'd2 ? 4'hd : 4'h9;
  endfunction
  always_comb begin
    a = '0;
    b = '0;
    for (int r = 0; r < 4; r++) a[r] = state_q[(4*r + int'(col_q))*8 +: 8];
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) b[r] = b[r] ^ gm(a[j], coef(2'(j - r)));
  end
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    col_d = col_q;
    case (fsm_q)
      IDLE: if (in_valid_i) begin
        fsm_d = BUSY;
        state_d = data_i;
        col_d = 2'd0;
      end
      BUSY: begin
        for (int r = 0; r < 4; r++) state_d[(4*r + int'(col_q))*8 +: 8] = b[r];
        col_d = col_q + 2'd1;
        fsm_d = col_q == 2'd3 ? DONE : BUSY;
      end
      DONE: fsm_d = out_ready_i ? IDLE : DONE;
      default: fsm_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      fsm_q <= IDLE;
      state_q <= '0;
      col_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      col_q <= col_d;
    end
  end
  assign in_ready_o = fsm_q == IDLE;
  assign out_valid_o = fsm_q == DONE;
  assign busy_o = fsm_q != IDLE;
  assign data_o = state_q;
endmodule

// File: tb/tb_aes_inv_mix_columns_iter.sv
// tb_aes_inv_mix_columns_iter: directed and round-trip checks of the iterative InvMixColumns unit
module tb_aes_inv_mix_columns_iter;
  logic clk = 1'b0;
  logic rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] din = '0, dout;
  logic in_ready, out_valid, busy;
  int assertions = 0, failures = 0;
  aes_inv_mix_columns_iter dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_i(din), .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(dout), .busy_o(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] mk(input logic [31:0] c0, c1, c2, c3);
    logic [3:0][31:0] cs;
    logic [127:0] s;
    cs = {c3, c2, c1, c0};
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[(4*r + c)*8 +: 8] = cs[c][31 - 8*r -: 8];
    return s;
  endfunction
  function automatic logic [7:0] x2(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[c*8 +: 8];
      a1 = s[(4 + c)*8 +: 8];
      a2 = s[(8 + c)*8 +: 8];
      a3 = s[(12 + c)*8 +: 8];
      o[c*8 +: 8] = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
      o[(4 + c)*8 +: 8] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
      o[(8 + c)*8 +: 8] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
      o[(12 + c)*8 +: 8] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
    end
    return o;
  endfunction
  task automatic run(input logic [127:0] d, output logic [127:0] r, output int lat);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    din = d;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = dout;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b data=%h, need 1 0 0 0", in_ready, out_valid, busy, dout);
    end
  endtask
  task automatic test_vector(input string name, input logic [127:0] d, input logic [127:0] exp);
    logic [127:0] r;
    int lat;
    run(d, r, lat);
    assertions++;
    if (r !== exp) begin
      failures++;
      $display("FAIL %s data: got %h need %h", name, r, exp);
    end
    assertions++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL %s latency: got %0d need 5", name, lat);
    end
    assertions++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s after handshake: in_ready=%b out_valid=%b need 1 0", name, in_ready, out_valid);
    end
  endtask
  task automatic test_backpressure();
    logic [127:0] exp, held;
    int t;
    bit bad;
    exp = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h01010101);
    @(negedge clk);
    in_valid = 1'b1;
    din = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h01010101);
    @(negedge clk);
    din = {16{8'h55}};
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    held = dout;
    assertions++;
    if (held !== exp) begin
      failures++;
      $display("FAIL backpressure data: got %h need %h", held, exp);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dout !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    assertions++;
    if (bad) begin
      failures++;
      $display("FAIL backpressure hold: data=%h out_valid=%b in_ready=%b need %h 1 0", dout, out_valid, in_ready, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    assertions++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure release: in_ready=%b out_valid=%b busy=%b need 1 0 0", in_ready, out_valid, busy);
    end
  endtask
  task automatic test_abort(input string name, input bit use_rst);
    bit pulse;
    @(negedge clk);
    in_valid = 1'b1;
    din = {16{8'ha7}};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else clear = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    assertions++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL %s state: in_ready=%b busy=%b data=%h need 1 0 0", name, in_ready, busy, dout);
    end
    pulse = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) pulse = 1'b1;
    end
    assertions++;
    if (pulse) begin
      failures++;
      $display("FAIL %s out_valid pulse: got 1 need 0", name);
    end
  endtask
  task automatic test_clear_done();
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    din = {16{8'h3c}};
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    assertions++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || dout !== '0 || t >= 20) begin
      failures++;
      $display("FAIL clear_done: in_ready=%b out_valid=%b busy=%b data=%h need 1 0 0 0", in_ready, out_valid, busy, dout);
    end
  endtask
  task automatic test_round_trip();
    logic [127:0] s, r;
    int lat, bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run(mix(s), r, lat);
      assertions++;
      if (r !== s || lat !== 5) begin
        failures++;
        if (bad++ < 5) $display("FAIL round_trip %0d: got %h need %h latency %0d", i, r, s, lat);
      end
    end
  endtask
  task automatic test_back_to_back();
    int acc[$];
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    din = {$urandom, $urandom, $urandom, $urandom};
    for (cyc = 0; cyc < 40; cyc++) begin
      if (in_ready) acc.push_back(cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    assertions++;
    if (acc.size() !== 7) begin
      failures++;
      $display("FAIL back_to_back count: got %0d need 7", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      assertions++;
      if (acc[i] - acc[i-1] !== 6) begin
        failures++;
        $display("FAIL back_to_back spacing %0d: got %0d need 6", i, acc[i] - acc[i-1]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_vector("standard", mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h01010101),
                mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h01010101));
    test_vector("all_c6", {16{8'hc6}}, {16{8'hc6}});
    test_vector("all_00", '0, '0);
    test_vector("d5_col", mk(32'hd5d5d7d6, 0, 0, 0), mk(32'hd4d4d4d5, 0, 0, 0));
    test_vector("d5_col3", mk(0, 0, 0, 32'hd5d5d7d6), mk(0, 0, 0, 32'hd4d4d4d5));
    test_backpressure();
    test_abort("clear_busy", 1'b0);
    test_abort("rst_busy", 1'b1);
    test_clear_done();
    test_round_trip();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule

// File: doc/aes_inv_mix_columns_iter.md
# aes_inv_mix_columns_iter

Iterative, column-serial AES InvMixColumns unit for the decryption datapath. It accepts one 128-bit AES state through a valid/ready handshake and transforms one 32-bit column per cycle using GF(2^8) constant multiplications. It presents the result through a second valid/ready handshake. It sits between the inverse-ShiftRows/inverse-SubBytes stage and the round-key adder. It trades the area of four parallel column multipliers for four cycles of latency.

## Interface
- No parameters; state width is fixed at 128 bits (16 bytes, 4 columns).
- clk_i  input  1  clock; all logic rising-edge.
- rst_i  input  1  reset; synchronous and active-high.
- clear_i  input  1  synchronous abort: return to IDLE, zero the state register.
- in_valid_i  input  1  data_i holds a valid state.
- in_ready_o  output  1  block can accept a state this cycle.
- data_i  input  128  input state; byte (row r, column c) at data_i[(4*r+c)*8 +: 8].
- out_valid_o  output  1  data_o holds the finished state.
- out_ready_i  input  1  consumer accepts data_o this cycle.
- data_o  output  128  transformed state, same byte layout as data_i.
- busy_o  output  1  high in BUSY or DONE.

## Operation
- Column c consists of bytes a0..a3 = rows 0..3 at byte indices c, 4+c, 8+c, 12+c.
- Per column, compute:
  - b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - b1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - b2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - b3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
- Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  - Build from xtime: x2 = {in[6:0],1'b0} ^ (in[7] ? 8'h1B : 8'h00); x4 = xtime(x2); x8 = xtime(x4).
  - 09 = x8^in; 0B = x8^x2^in; 0D = x8^x4^in; 0E = x8^x4^x2.
- Exactly one column-multiplier instance, muxed by a 2-bit column counter col_q.
- FSM states:
  - IDLE: in_ready_o=1. On in_valid_i, load data_i into state_q, set col_q=0, go to BUSY.
  - BUSY: each cycle, write the result of column col_q back into state_q and increment col_q. When col_q==3, go to DONE and wrap col_q to 0.
  - DONE: out_valid_o=1 and data_o=state_q. On out_ready_i, go to IDLE. Otherwise hold: data_o stays stable and out_valid_o stays high.
- in_ready_o is high only in IDLE. The block does not accept a new state in the same cycle as an output handshake.
- data_o is driven from state_q at all times. Only data_o during out_valid_o is meaningful.
- Priority: rst_i > clear_i > FSM.
  - clear_i in any state: IDLE, state_q=0, col_q=0, no output produced. An in_valid_i in the same cycle is not accepted.
- Reset values: state IDLE, state_q=0, col_q=0.
  - Outputs out of reset: out_valid_o=0, busy_o=0, data_o=0, in_ready_o=1 (the first cycle after rst_i deasserts).
- Reset or clear asserted mid-BUSY or in DONE discards the in-flight state.
- No internal buffering beyond state_q; throughput is one state per 6 cycles minimum.

## Timing
- Cycle 0: in_valid_i & in_ready_o sampled high at the edge; state_q loaded.
- Cycles 1–4: BUSY, one column per cycle; columns 0,1,2,3 are updated at the edges ending cycles 1–4.
- Cycle 5: out_valid_o=1 (first cycle DONE), 5 cycles after the accepting edge.
- If out_ready_i is high in cycle 5, in_ready_o=1 in cycle 6.
- Back-to-back states are accepted no closer than 6 cycles apart.
- All outputs are registered or decoded from FSM state only; there is no combinational path from in_valid_i or out_ready_i to any output.

## Test plan
- Standard column vector: load column 0 = (8E,4D,A1,BC), column 1 = (9F,DC,58,9D), columns 2–3 = (01,01,01,01).
  - Required: column 0 = (DB,13,53,45), column 1 = (F2,0A,22,5C), columns 2–3 = (01,01,01,01).
  - out_valid_o rises exactly 5 cycles after accept.
- Fixed points: state all-C6 -> all-C6; state all-00 -> all-00; column (D5,D5,D7,D6) -> (D4,D4,D4,D5).
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE.
  - Required: data_o stable, out_valid_o high, in_ready_o low, new in_valid_i ignored.
  - Release: one handshake, then in_ready_o=1 the following cycle.
- Abort: assert clear_i when col_q==2 in BUSY.
  - Required: next cycle IDLE, state_q=0, in_ready_o=1, no out_valid_o pulse.
  - Repeat with synchronous rst_i and with clear_i while in DONE.
- Round trip and throughput: 1000 random states through a reference MixColumns model followed by this block.
  - Required: output equals the original state.
  - With out_ready_i tied high and in_valid_i held high, accepts occur every 6 cycles.
